// File: rtl/multicycle_control_pkg.sv
// Shared RISC-V multicycle control definitions.
// Holds the state codes, the decoded opcodes and the ALU operand/operation encodings.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RTWB   = 4'd7,
    S_BRANCH = 4'd8
  } state_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  function automatic logic is_legal_op(input logic [6:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) || (op == OP_BEQ);
  endfunction

endpackage

// File: rtl/multicycle_control.sv
// Multicycle RISC-V main control FSM: state register, next-state logic,
// control-signal decode, illegal-opcode pulse and retired-instruction counter.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             IRWrite,
  output logic             ALUSrcA,
  output logic             RegWrite,
  output logic             PCSource,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [3:0]       state,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);

  logic [3:0]       state_r;
  logic [3:0]       next_s;
  logic             retire_s;
  logic             illegal_r;
  logic [CNT_W-1:0] count_r;

  logic pc_write_s, pc_write_cond_s, ior_d_s, mem_read_s, mem_write_s;
  logic mem_to_reg_s, ir_write_s, alu_src_a_s, reg_write_s, pc_source_s;
  logic [1:0] alu_src_b_s, alu_op_s;

  // State, illegal-op pulse and retired-instruction counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= S_FETCH;
      illegal_r <= 1'b0;
      count_r   <= '0;
    end else begin
      state_r   <= next_s;
      illegal_r <= (state_r == S_DECODE) && !is_legal_op(opcode);
      count_r   <= retire_s ? count_r + CNT_W'(1) : count_r;
    end
  end

  // Next state, retirement and per-state control decode
  always_comb begin
    next_s          = S_FETCH;
    retire_s        = 1'b0;
    pc_write_s      = 1'b0;
    pc_write_cond_s = 1'b0;
    ior_d_s         = 1'b0;
    mem_read_s      = 1'b0;
    mem_write_s     = 1'b0;
    mem_to_reg_s    = 1'b0;
    ir_write_s      = 1'b0;
    alu_src_a_s     = 1'b0;
    reg_write_s     = 1'b0;
    pc_source_s     = 1'b0;
    alu_src_b_s     = SRCB_REG;
    alu_op_s        = ALUOP_ADD;
    case (state_r)
      S_FETCH: begin
        mem_read_s  = 1'b1;
        alu_src_b_s = SRCB_FOUR;
        ir_write_s  = mem_ready;
        pc_write_s  = mem_ready;
        next_s      = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b_s = SRCB_IMM;
        if ((opcode == OP_LW) || (opcode == OP_SW)) next_s = S_MEMADR;
        else if (opcode == OP_RTYPE)                next_s = S_EXEC;
        else if (opcode == OP_BEQ)                  next_s = S_BRANCH;
        else                                        next_s = S_FETCH;
      end
      S_MEMADR: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = SRCB_IMM;
        next_s      = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_read_s = 1'b1;
        ior_d_s    = 1'b1;
        next_s     = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        reg_write_s  = 1'b1;
        mem_to_reg_s = 1'b1;
        retire_s     = 1'b1;
      end
      S_MEMWR: begin
        mem_write_s = 1'b1;
        ior_d_s     = 1'b1;
        retire_s    = mem_ready;
        next_s      = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        alu_src_a_s = 1'b1;
        alu_op_s    = ALUOP_FUNCT;
        next_s      = S_RTWB;
      end
      S_RTWB: begin
        reg_write_s = 1'b1;
        retire_s    = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_s     = 1'b1;
        alu_op_s        = ALUOP_SUB;
        pc_write_cond_s = 1'b1;
        pc_source_s     = 1'b1;
        retire_s        = 1'b1;
      end
      default: next_s = S_FETCH;
    endcase
  end

  // Architectural write enables are forced off while reset is held
  assign PCWrite     = pc_write_s      & ~rst;
  assign PCWriteCond = pc_write_cond_s & ~rst;
  assign IRWrite     = ir_write_s      & ~rst;
  assign MemRead     = mem_read_s      & ~rst;
  assign MemWrite    = mem_write_s     & ~rst;
  assign RegWrite    = reg_write_s     & ~rst;
  assign IorD        = ior_d_s;
  assign MemtoReg    = mem_to_reg_s;
  assign ALUSrcA     = alu_src_a_s;
  assign PCSource    = pc_source_s;
  assign ALUSrcB     = alu_src_b_s;
  assign ALUOp       = alu_op_s;
  assign state       = state_r;
  assign illegal_op  = illegal_r;
  assign instr_count = count_r;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control; a second instance with a
// 4-bit counter shares the stimulus to exercise counter wrap.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic       mem_ready = 1'b1;

  logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, PCSource;
  logic [1:0] ALUSrcB, ALUOp;
  logic [3:0] state;
  logic illegal_op;
  logic [15:0] instr_count;

  logic w_PCWrite, w_PCWriteCond, w_IorD, w_MemRead, w_MemWrite, w_MemtoReg, w_IRWrite, w_ALUSrcA, w_RegWrite, w_PCSource;
  logic [1:0] w_ALUSrcB, w_ALUOp;
  logic [3:0] w_state;
  logic w_illegal_op;
  logic [3:0] w_instr_count;

  int n_assert = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  multicycle_control #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .ALUSrcA(ALUSrcA),
    .RegWrite(RegWrite), .PCSource(PCSource), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .state(state), .illegal_op(illegal_op), .instr_count(instr_count)
  );

  multicycle_control #(.CNT_W(4)) dut_w (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(w_PCWrite), .PCWriteCond(w_PCWriteCond), .IorD(w_IorD), .MemRead(w_MemRead),
    .MemWrite(w_MemWrite), .MemtoReg(w_MemtoReg), .IRWrite(w_IRWrite), .ALUSrcA(w_ALUSrcA),
    .RegWrite(w_RegWrite), .PCSource(w_PCSource), .ALUSrcB(w_ALUSrcB), .ALUOp(w_ALUOp),
    .state(w_state), .illegal_op(w_illegal_op), .instr_count(w_instr_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one cycle; inputs may then be changed, outputs sampled after settle
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    // reset held in FETCH with mem_ready=1: write enables gated
    tick(); tick();
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_count", 32'(instr_count), 32'd0);
    check("rst_illegal", 32'(illegal_op), 32'd0);
    check("rst_memread", 32'(MemRead), 32'd0);
    check("rst_pcwrite", 32'(PCWrite), 32'd0);
    check("rst_irwrite", 32'(IRWrite), 32'd0);

    // R-type: 0,1,6,7,0
    rst = 1'b0; opcode = 7'b0110011; mem_ready = 1'b1; #1;
    check("r_fetch_state", 32'(state), 32'd0);
    check("r_fetch_memread", 32'(MemRead), 32'd1);
    check("r_fetch_irwrite", 32'(IRWrite), 32'd1);
    check("r_fetch_pcwrite", 32'(PCWrite), 32'd1);
    check("r_fetch_srcb", 32'(ALUSrcB), 32'd1);
    tick(); check("r_decode_state", 32'(state), 32'd1);
    check("r_decode_srcb", 32'(ALUSrcB), 32'd2);
    tick(); check("r_exec_state", 32'(state), 32'd6);
    check("r_exec_aluop", 32'(ALUOp), 32'd2);
    check("r_exec_srca", 32'(ALUSrcA), 32'd1);
    check("r_exec_srcb", 32'(ALUSrcB), 32'd0);
    tick(); check("r_rtwb_state", 32'(state), 32'd7);
    check("r_rtwb_regwrite", 32'(RegWrite), 32'd1);
    check("r_rtwb_memtoreg", 32'(MemtoReg), 32'd0);
    tick(); check("r_done_state", 32'(state), 32'd0);
    check("r_done_count", 32'(instr_count), 32'd1);

    // FETCH stall: no IR/PC write while memory not ready
    mem_ready = 1'b0; opcode = 7'b0000011; #1;
    check("stall_irwrite", 32'(IRWrite), 32'd0);
    check("stall_pcwrite", 32'(PCWrite), 32'd0);
    check("stall_memread", 32'(MemRead), 32'd1);
    tick(); check("stall_state", 32'(state), 32'd0);

    // LW with 3 wait cycles in MEMRD; opcode garbage there must not matter
    mem_ready = 1'b1;
    tick(); check("lw_decode", 32'(state), 32'd1);
    tick(); check("lw_memadr", 32'(state), 32'd2);
    check("lw_memadr_srca", 32'(ALUSrcA), 32'd1);
    mem_ready = 1'b0;
    tick();
    opcode = 7'b1111111;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("lw_memrd_state", 32'(state), 32'd3);
      check("lw_memrd_memread", 32'(MemRead), 32'd1);
      check("lw_memrd_iord", 32'(IorD), 32'd1);
      tick();
    end
    mem_ready = 1'b1; #1;
    check("lw_memrd4_state", 32'(state), 32'd3);
    check("lw_memrd4_memread", 32'(MemRead), 32'd1);
    tick(); check("lw_memwb_state", 32'(state), 32'd4);
    check("lw_memwb_regwrite", 32'(RegWrite), 32'd1);
    check("lw_memwb_memtoreg", 32'(MemtoReg), 32'd1);
    tick(); check("lw_done_state", 32'(state), 32'd0);
    check("lw_done_count", 32'(instr_count), 32'd2);
    check("lw_no_illegal", 32'(illegal_op), 32'd0);

    // SW
    opcode = 7'b0100011;
    tick(); tick(); check("sw_memadr", 32'(state), 32'd2);
    check("sw_memadr_aluop", 32'(ALUOp), 32'd0);
    check("sw_memadr_srcb", 32'(ALUSrcB), 32'd2);
    tick(); check("sw_memwr", 32'(state), 32'd5);
    check("sw_memwrite", 32'(MemWrite), 32'd1);
    check("sw_iord", 32'(IorD), 32'd1);
    tick(); check("sw_done_state", 32'(state), 32'd0);
    check("sw_done_count", 32'(instr_count), 32'd3);

    // BEQ
    opcode = 7'b1100011;
    tick(); tick(); check("beq_state", 32'(state), 32'd8);
    check("beq_aluop", 32'(ALUOp), 32'd1);
    check("beq_pcwritecond", 32'(PCWriteCond), 32'd1);
    check("beq_pcsource", 32'(PCSource), 32'd1);
    check("beq_pcwrite", 32'(PCWrite), 32'd0);
    tick(); check("beq_done_state", 32'(state), 32'd0);
    check("beq_done_count", 32'(instr_count), 32'd4);

    // illegal opcode: single-cycle pulse, no count
    opcode = 7'b1111111;
    tick(); check("ill_decode", 32'(state), 32'd1);
    check("ill_pre_pulse", 32'(illegal_op), 32'd0);
    mem_ready = 1'b0;
    tick(); check("ill_state", 32'(state), 32'd0);
    check("ill_pulse", 32'(illegal_op), 32'd1);
    check("ill_count", 32'(instr_count), 32'd4);
    tick(); check("ill_pulse_end", 32'(illegal_op), 32'd0);

    // reset while stalled in MEMWR abandons the store
    mem_ready = 1'b1; opcode = 7'b0100011;
    tick(); tick(); mem_ready = 1'b0;
    tick(); check("rstwr_memwr", 32'(state), 32'd5);
    tick(); check("rstwr_hold", 32'(state), 32'd5);
    rst = 1'b1; #1;
    check("rstwr_memwrite", 32'(MemWrite), 32'd0);
    check("rstwr_regwrite", 32'(RegWrite), 32'd0);
    tick(); check("rstwr_state", 32'(state), 32'd0);
    check("rstwr_count", 32'(instr_count), 32'd0);
    check("rstwr_w_count", 32'(w_instr_count), 32'd0);

    // 16 R-types: 4-bit counter wraps 15 -> 0
    rst = 1'b0; mem_ready = 1'b1; opcode = 7'b0110011;
    for (int i = 1; i <= 16; i++) begin
      tick(); tick(); tick(); tick();
      if (i == 15) check("wrap_15", 32'(w_instr_count), 32'd15);
    end
    check("wrap_0", 32'(w_instr_count), 32'd0);
    check("wide_16", 32'(instr_count), 32'd16);
    check("wrap_state", 32'(state), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter: CNT_W, 16, width of retired-instruction counter.
REQ-002 SHALL have port: clk  in  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst  in  1  reset; synchronous, active-high.
REQ-004 SHALL have port: opcode  in  7  instruction[6:0] from instruction register.
REQ-005 SHALL have port: mem_ready  in  1  memory access completes this cycle.
REQ-006 SHALL have ports (out, 1 each): PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, PCSource.
REQ-007 SHALL have ports: ALUSrcB  out  2  (00 reg B, 01 const 4, 10 imm); ALUOp  out  2  (00 add, 01 sub/branch, 10 use funct fields) to the ALU control decoder.
REQ-008 SHALL have ports: state  out  4  current state; illegal_op  out  1  one-cycle pulse; instr_count  out  CNT_W  retired instructions.

Function
REQ-009 SHALL implement states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RTWB=7, BRANCH=8; codes 9-15 SHALL go to FETCH next cycle.
REQ-010 SHALL drive all outputs not listed for a state to 0.
REQ-011 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00; IRWrite=1 and PCWrite=1 only in the cycle mem_ready=1 (Mealy); stay until mem_ready=1, then DECODE.
REQ-012 DECODE: ALUSrcA=0, ALUSrcB=10, ALUOp=00; next by opcode: 0000011 or 0100011 -> MEMADR, 0110011 -> EXEC, 1100011 -> BRANCH, else FETCH with illegal_op=1 in the following cycle.
REQ-013 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; -> MEMRD if opcode=0000011, else MEMWR.
REQ-014 MEMRD: MemRead=1, IorD=1; stay until mem_ready=1, then MEMWB.
REQ-015 MEMWB: RegWrite=1, MemtoReg=1; -> FETCH.
REQ-016 MEMWR: MemWrite=1, IorD=1; stay until mem_ready=1, then FETCH.
REQ-017 EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10; -> RTWB.
REQ-018 RTWB: RegWrite=1, MemtoReg=0; -> FETCH.
REQ-019 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=1; -> FETCH.
REQ-020 instr_count SHALL increment by 1 on the edge leaving MEMWB, MEMWR (mem_ready=1), RTWB or BRANCH; wraps from all-ones to 0; illegal opcodes not counted.
REQ-021 Latencies with mem_ready held 1: LW 5 cycles, SW 4, R-type 4, BEQ 3, illegal 2.
REQ-022 mem_ready SHALL be ignored outside FETCH, MEMRD, MEMWR.
REQ-023 opcode SHALL be sampled only in DECODE and MEMADR; changes elsewhere have no effect.

Reset
REQ-024 On clock edge with rst=1: state=FETCH, instr_count=0, illegal_op=0.
REQ-025 While rst=1, PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite, RegWrite SHALL be 0 regardless of state or mem_ready.
REQ-026 Reset asserted mid-instruction (any state, including waiting on mem_ready) SHALL abandon it without counting it.

Structure
REQ-027 State codes, the four opcode constants and ALUOp/ALUSrcB encodings SHALL live in the shared RISC-V control definitions package/include.
REQ-028 Single module: state register, next-state logic, output decode and counter; no sub-module required.

Verification
REQ-029 Reset then opcode=0110011, mem_ready=1 -> states 0,1,6,7,0; ALUOp=10 in EXEC; RegWrite=1, MemtoReg=0 in RTWB; instr_count=1.
REQ-030 opcode=0000011, mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles, MemRead=IorD=1 throughout; MEMWB RegWrite=MemtoReg=1; count +1.
REQ-031 opcode=0100011 then 1100011 -> SW: MemWrite=1 in MEMWR, ALUOp=00 in MEMADR; BEQ: ALUOp=01, PCWriteCond=PCSource=1 in BRANCH; count +2.
REQ-032 opcode=1111111 in DECODE -> FETCH next, illegal_op=1 for exactly one cycle, count unchanged.
REQ-033 rst=1 while in MEMWR with mem_ready=0 -> next state FETCH, all write enables 0 during reset, instr_count=0.
REQ-034 CNT_W=4, 16 R-type instructions -> instr_count wraps 15 -> 0.
